stk_cmd_arb: RTL

//  Upstream front end of the stack engine. Accepts stack commands from ENGS_N

---
 rtl/stk_cmd_arb.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/stk_cmd_arb.sv
// ---------------------------------------------------------------------------
// stk_cmd_arb
//   Front end of the stack engine. ENGS_N client engines present stack
//   commands; one is granted per cycle, round-robin. Each grant is checked
//   against that engine's depth counter. Legal PUSH/POP go out through a
//   one-entry issue register to the stack datapath. NOP, INV, overflow and
//   underflow complete locally with a single-cycle status pulse.
//
// Handshake: cmd_rdy_o[g] is combinational and is high only in the cycle that
//   engine g is granted, so a command is taken when cmd_vld_i[g] & cmd_rdy_o[g].
//   An issue is accepted when iss_vld_o & iss_rdy_i. rsp_vld_o cannot be
//   back-pressured.
//
// Opcode encoding:  NOP=00, PUSH=01, POP=10, INV=11
// Status encoding:  OKAY=00, FULL=01, EMPTY=10, BADOP=11
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   cmd_vld_i     per-engine command valid
//   cmd_opcode_i  per-engine opcode, engine e at [2*e +: 2]
//   cmd_dat_i     per-engine push data, engine e at [DATA_W*e +: DATA_W]
//   cmd_rdy_o     one-hot grant/accept
//   iss_*         issued PUSH/POP to the stack datapath
//   rsp_*         local completion pulse with status
//   dbg_rr_ptr    current round-robin pointer (highest-priority engine)
// ---------------------------------------------------------------------------
module stk_cmd_arb #(
    parameter int ENGS_N    = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH_MAX = 1024,
    localparam int ENGID_W  = (ENGS_N > 1) ? $clog2(ENGS_N) : 1,
    localparam int DEPTH_W  = $clog2(DEPTH_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ENGS_N-1:0]          cmd_vld_i,
    input  logic [ENGS_N*2-1:0]        cmd_opcode_i,
    input  logic [ENGS_N*DATA_W-1:0]   cmd_dat_i,
    output logic [ENGS_N-1:0]          cmd_rdy_o,
    output logic                       iss_vld_o,
    output logic [ENGID_W-1:0]         iss_engid_o,
    output logic [1:0]                 iss_opcode_o,
    output logic [DATA_W-1:0]          iss_dat_o,
    input  logic                       iss_rdy_i,
    output logic                       rsp_vld_o,
    output logic [ENGID_W-1:0]         rsp_engid_o,
    output logic [1:0]                 rsp_status_o,
    output logic [ENGID_W-1:0]         dbg_rr_ptr
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

    localparam logic [1:0] ST_OKAY  = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_EMPTY = 2'b10;
    localparam logic [1:0] ST_BADOP = 2'b11;

    logic [ENGID_W-1:0] rr_ptr;
    logic [DEPTH_W-1:0] depth [ENGS_N];

    logic               slot_free;
    logic               gnt_vld;
    logic [ENGID_W-1:0] gnt_idx;
    logic [1:0]         gnt_op;
    logic [DATA_W-1:0]  gnt_dat;
    logic [DEPTH_W-1:0] gnt_depth;
    logic               do_issue;
    logic               do_inc;
    logic               do_dec;
    logic [1:0]         loc_status;
    logic [ENGID_W-1:0] ptr_next;

    assign dbg_rr_ptr = rr_ptr;

    // The issue register can take a new entry when empty or draining this cycle.
    assign slot_free = !iss_vld_o || iss_rdy_i;

    // Round-robin search starting at rr_ptr, wrapping at ENGS_N.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!rst && slot_free) begin
            for (int i = 0; i < ENGS_N; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= ENGS_N) idx = idx - ENGS_N;
                if (!gnt_vld && cmd_vld_i[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = ENGID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        cmd_rdy_o = '0;
        if (gnt_vld) cmd_rdy_o[gnt_idx] = 1'b1;
    end

    assign gnt_op    = cmd_opcode_i[2*int'(gnt_idx) +: 2];
    assign gnt_dat   = cmd_dat_i[DATA_W*int'(gnt_idx) +: DATA_W];
    assign gnt_depth = depth[gnt_idx];
    assign ptr_next  = (int'(gnt_idx) == ENGS_N - 1) ? '0 : gnt_idx + 1'b1;

    // Decode against the depth seen at grant; depth is committed immediately
    // because the datapath always completes what it is issued.
    always_comb begin
        do_issue   = 1'b0;
        do_inc     = 1'b0;
        do_dec     = 1'b0;
        loc_status = ST_OKAY;
        unique case (gnt_op)
            OP_PUSH: begin
                if (gnt_depth == DEPTH_W'(DEPTH_MAX)) begin
                    loc_status = ST_FULL;
                end else begin
                    do_issue = 1'b1;
                    do_inc   = 1'b1;
                end
            end
            OP_POP: begin
                if (gnt_depth == '0) begin
                    loc_status = ST_EMPTY;
                end else begin
                    do_issue = 1'b1;
                    do_dec   = 1'b1;
                end
            end
            OP_NOP:  loc_status = ST_OKAY;
            OP_INV:  loc_status = ST_BADOP;
            default: loc_status = ST_BADOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            iss_vld_o    <= 1'b0;
            iss_engid_o  <= '0;
            iss_opcode_o <= '0;
            iss_dat_o    <= '0;
            rsp_vld_o    <= 1'b0;
            rsp_engid_o  <= '0;
            rsp_status_o <= '0;
            for (int e = 0; e < ENGS_N; e++) depth[e] <= '0;
        end else begin
            // Issue register: hold while stalled, otherwise reload or clear.
            if (gnt_vld && do_issue) begin
                iss_vld_o    <= 1'b1;
                iss_engid_o  <= gnt_idx;
                iss_opcode_o <= gnt_op;
                iss_dat_o    <= (gnt_op == OP_PUSH) ? gnt_dat : '0;
            end else if (iss_rdy_i) begin
                iss_vld_o    <= 1'b0;
                iss_engid_o  <= '0;
                iss_opcode_o <= '0;
                iss_dat_o    <= '0;
            end

            // Local completion is a one-cycle pulse; fields read zero otherwise.
            if (gnt_vld && !do_issue) begin
                rsp_vld_o    <= 1'b1;
                rsp_engid_o  <= gnt_idx;
                rsp_status_o <= loc_status;
            end else begin
                rsp_vld_o    <= 1'b0;
                rsp_engid_o  <= '0;
                rsp_status_o <= '0;
            end

            if (gnt_vld) begin
                rr_ptr <= ptr_next;
                if (do_inc) depth[gnt_idx] <= gnt_depth + 1'b1;
                if (do_dec) depth[gnt_idx] <= gnt_depth - 1'b1;
            end
        end
    end

endmodule
